multibyte_add_sequencer: RTL
============================

# multibyte_add_sequencer

Sequential controller that performs BYTES×8-bit add/subtract by time-multiplexing one external 8-bit two-nibble adder. It issues one byte per cycle and feeds the adder's carry back as the next byte's carry-in. It sits directly upstream of that adder, driving its nibble operands and carry-in, and directly downstream of it, consuming its sum and carry-out. Operands arrive and results leave over valid/ready handshakes.

## Interface
- BYTES, 4: operand width in bytes (≥1); data width W = 8*BYTES.
- clk  in  1  rising-edge clock. One clock domain; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- sub  in  1  1 = A−B, 0 = A+B+cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum/difference.
- carry_out  out  1  final carry. For sub, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- adder_a_msb, adder_a_lsb, adder_b_msb, adder_b_lsb  out  4 each  current byte nibbles to adder.
- adder_carry_in  out  1  carry to adder.
- adder_sum  in  8  adder sum (combinational, same cycle).
- adder_carry_out  in  1  adder carry-out.

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready:
    - latch a_reg=op_a;
    - b_reg = sub ? ~op_b : op_b;
    - carry_reg = sub ? 1 : cin;
    - idx=0; go to RUN.
- RUN:
  - Drive adder_a_{msb,lsb} = a_reg byte idx [7:4]/[3:0], likewise b.
  - adder_carry_in = carry_reg.
  - On each edge:
    - result byte idx ← adder_sum;
    - carry_reg ← adder_carry_out;
    - idx++.
  - When idx==BYTES−1, go to DONE after the capture.
- DONE:
  - out_valid=1; result, carry_out=carry_reg and overflow are held stable.
  - On out_ready, go to IDLE.
- overflow = (a_reg[W−1]==b_reg[W−1]) && (result[W−1]!=a_reg[W−1]). It uses the post-inversion b_reg and is computed in DONE only.
- Adder drive outside RUN: all nibbles 0 and carry_in 0.
- in_ready=0 in RUN and DONE; in_valid in those states is ignored and not consumed.
- BYTES=1: RUN lasts exactly one cycle.
- Mod-2^W wraparound; no saturation.

## Timing
- Reset values:
  - in_ready=1 after release; it is 0 while rst_n=0.
  - out_valid=0, result=0, carry_out=0, overflow=0.
  - Adder drive is 0.
- Latency: out_valid rises BYTES cycles after the accepting edge. Throughput is one op per BYTES+1 cycles minimum.
- DONE→IDLE happens on the out_ready edge. The next accept is possible at the following edge; there is no same-cycle accept in DONE.
- Backpressure: out_valid stays high and result is stable for as long as out_ready=0.
- Reset mid-RUN or mid-DONE: the op is aborted, outputs go to reset values immediately (async), and no partial result is ever presented.
- The adder path is combinational within one cycle: the clk period must cover the adder's ripple plus capture.

## Structure
- Shared package:
  - FSM state enum;
  - BYTE_W=8, NIBBLE_W=4 constants;
  - index width function clog2(BYTES).
- The adder is not instantiated inside this block. The parent connects adder_* ports to the existing 8-bit adder.
- One natural sub-module: byte_slice_mux, which selects byte idx of a_reg/b_reg and splits it into msb/lsb nibbles.
- Bench top instantiates the sequencer plus the real adder.

## Test plan
- BYTES=4, add, A=0x000000FF, B=0x00000001, cin=0 → result 0x00000100, carry_out 0, overflow 0; out_valid 4 cycles after accept.
- Add A=0xFFFFFFFF, B=0x00000001, cin=0 → result 0x00000000, carry_out 1, overflow 0. Add A=0x7FFFFFFF, B=1 → 0x80000000, overflow 1.
- sub A=5, B=7 → 0xFFFFFFFE, carry_out 0, overflow 0. Sub A=0x80000000, B=1 → 0x7FFFFFFF, carry_out 1, overflow 1.
- Backpressure: out_ready held 0 for 3 cycles with in_valid=1 and a new operand → result stable, in_ready 0, second operand accepted only the cycle after the out_ready handshake.
- Reset asserted after 2 RUN cycles → all outputs 0 immediately. After release in_ready=1, and the next op A=0x12345678+B=0x11111111 yields 0x23456789.
- BYTES=1 build: A=0xF0, B=0x20, add → 0x10, carry_out 1; out_valid 1 cycle after accept.

Source files
------------

// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared types and constants for the multibyte add/subtract sequencer and its byte slice mux.
// Holds the FSM state encoding, the byte/nibble widths and the byte-index width helper.
package multibyte_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W   = 8;
  localparam int NIBBLE_W = 4;

  // A single-byte build still needs a 1-bit index.
  function automatic int idx_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/multibyte_add_sequencer_byte_slice_mux.sv
// Selects byte idx of both operand words and splits it into nibbles; purely combinational, zero latency.
// No handshake: when en is low every nibble is driven to zero.
module multibyte_add_sequencer_byte_slice_mux
  import multibyte_add_sequencer_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int W     = 8 * BYTES,
  parameter int IW    = idx_w(BYTES)
) (
  input  logic [W-1:0]        a_word,
  input  logic [W-1:0]        b_word,
  input  logic [IW-1:0]       idx,
  input  logic                en,
  output logic [NIBBLE_W-1:0] a_msb,
  output logic [NIBBLE_W-1:0] a_lsb,
  output logic [NIBBLE_W-1:0] b_msb,
  output logic [NIBBLE_W-1:0] b_lsb
);

  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;

  always_comb begin
    a_byte = a_word[BYTE_W*int'(idx) +: BYTE_W];
    b_byte = b_word[BYTE_W*int'(idx) +: BYTE_W];
    a_msb  = '0;
    a_lsb  = '0;
    b_msb  = '0;
    b_lsb  = '0;
    if (en) begin
      a_msb = a_byte[BYTE_W-1:NIBBLE_W];
      a_lsb = a_byte[NIBBLE_W-1:0];
      b_msb = b_byte[BYTE_W-1:NIBBLE_W];
      b_lsb = b_byte[NIBBLE_W-1:0];
    end
  end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial W-bit add/sub through one external 8-bit adder; result valid BYTES cycles after accept.
// in_ready is low while busy; the result is held in DONE for as long as out_ready stays low.
module multibyte_add_sequencer
  import multibyte_add_sequencer_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*BYTES-1:0]    op_a,
  input  logic [8*BYTES-1:0]    op_b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*BYTES-1:0]    result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic [NIBBLE_W-1:0]   adder_a_msb,
  output logic [NIBBLE_W-1:0]   adder_a_lsb,
  output logic [NIBBLE_W-1:0]   adder_b_msb,
  output logic [NIBBLE_W-1:0]   adder_b_lsb,
  output logic                  adder_carry_in,
  input  logic [BYTE_W-1:0]     adder_sum,
  input  logic                  adder_carry_out
);

  localparam int W  = 8 * BYTES;
  localparam int IW = idx_w(BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_reg, b_reg, result_reg;
  logic          carry_reg;
  logic [IW-1:0] idx_q;
  logic          accept, capture, in_run, in_done;

  assign in_run  = (state_q == RUN);
  assign in_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        capture = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      idx_q      <= '0;
    end else if (accept) begin
      a_reg     <= op_a;
      b_reg     <= sub ? ~op_b : op_b;
      carry_reg <= sub ? 1'b1 : cin;
      idx_q     <= '0;
    end else if (capture) begin
      result_reg[BYTE_W*int'(idx_q) +: BYTE_W] <= adder_sum;
      carry_reg <= adder_carry_out;
      // Stop at the last byte so idx never points past the operand.
      idx_q     <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  multibyte_add_sequencer_byte_slice_mux #(
    .BYTES (BYTES),
    .W     (W),
    .IW    (IW)
  ) u_byte_slice_mux (
    .a_word (a_reg),
    .b_word (b_reg),
    .idx    (idx_q),
    .en     (in_run),
    .a_msb  (adder_a_msb),
    .a_lsb  (adder_a_lsb),
    .b_msb  (adder_b_msb),
    .b_lsb  (adder_b_lsb)
  );

  assign adder_carry_in = in_run & carry_reg;

  // Outputs are gated by DONE so a partially built result is never visible.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = in_done;
  assign result    = in_done ? result_reg : '0;
  assign carry_out = in_done & carry_reg;
  assign overflow  = in_done & (a_reg[W-1] == b_reg[W-1]) & (result_reg[W-1] != a_reg[W-1]);

endmodule
